// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and constants for the MIPS load/store unit.
// Op encoding, FSM states and big-endian lane offsets.
package mips_cpu_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // Big-endian: offset 0 is the most significant byte/half of the word.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic [1:0] LANE_H0 = 2'd0;
  localparam logic [1:0] LANE_H2 = 2'd2;

  function automatic logic is_store(lsu_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_lane.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module mips_cpu_lsu_lane
  import mips_cpu_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rword[31:24];
    case (addr_lo)
      LANE_B0: byte_val = rword[31:24];
      LANE_B1: byte_val = rword[23:16];
      LANE_B2: byte_val = rword[15:8];
      LANE_B3: byte_val = rword[7:0];
      default: byte_val = rword[31:24];
    endcase
    half_val = (addr_lo == LANE_H2) ? rword[15:0] : rword[31:16];
  end

  always_comb begin
    load_data = 32'h0;
    case (op)
      OP_LB:   load_data = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_data = {24'h0, byte_val};
      OP_LH:   load_data = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_data = {16'h0, half_val};
      OP_LW:   load_data = rword;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merged_word = rword;
    case (op)
      OP_SB: begin
        case (addr_lo)
          LANE_B0: merged_word[31:24] = wdata[7:0];
          LANE_B1: merged_word[23:16] = wdata[7:0];
          LANE_B2: merged_word[15:8]  = wdata[7:0];
          LANE_B3: merged_word[7:0]   = wdata[7:0];
          default: merged_word        = rword;
        endcase
      end
      OP_SH: begin
        if (addr_lo == LANE_H0) merged_word[31:16] = wdata[15:0];
        else                    merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit driving the word-wide memory data port; sub-word stores are read-modify-write.
// Optional MIPS_LSU_ALIGN_CHECK_EN enables misalignment/range errors; otherwise addresses are forced aligned.
module mips_cpu_lsu
  import mips_cpu_lsu_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = 32'h00001000,
  parameter int          DATA_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [31:0] DATA_LIMIT = DATA_BASE + 32'(4 * DATA_WORDS);

  lsu_state_t  state_reg;
  lsu_op_t     op_reg;
  logic [1:0]  lo_reg;
  logic [31:0] addr_reg;
  logic [31:0] wword_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  lsu_op_t     req_op_t;
  logic [1:0]  lo_next;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_op_t     = lsu_op_t'(req_op);
  assign out_of_range = (req_addr < DATA_BASE) || (req_addr >= DATA_LIMIT);

  always_comb begin
    lo_next    = req_addr[1:0];
    misaligned = 1'b0;
    case (req_op_t)
      OP_LH, OP_LHU, OP_SH: begin
        lo_next    = {req_addr[1], 1'b0};
        misaligned = req_addr[0];
      end
      OP_LW, OP_SW: begin
        lo_next    = 2'b00;
        misaligned = |req_addr[1:0];
      end
      default: ;
    endcase
  end

`ifdef MIPS_LSU_ALIGN_CHECK_EN
  assign req_err  = misaligned | out_of_range;
  assign resp_err = resp_err_reg;
`else
  logic unused_cfg;
  assign req_err    = 1'b0;
  assign resp_err   = 1'b0;
  assign unused_cfg = ^{misaligned, out_of_range, resp_err_reg};
`endif

  mips_cpu_lsu_lane u_lane (
    .op          (op_reg),
    .addr_lo     (lo_reg),
    .rword       (data_readdata),
    .wdata       (wword_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_LB;
      lo_reg         <= 2'b00;
      addr_reg       <= 32'h0;
      wword_reg      <= 32'h0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            op_reg         <= req_op_t;
            lo_reg         <= lo_next;
            addr_reg       <= {req_addr[31:2], 2'b00};
            wword_reg      <= req_wdata;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= req_err;
            if (req_err)                state_reg <= ST_RESP;
            else if (req_op_t == OP_SW) state_reg <= ST_WR;
            else                        state_reg <= ST_RD;
          end
        end
        ST_RD: begin
          // Stores reuse wword_reg: it holds the store data until the merge overwrites it.
          if (is_store(op_reg)) begin
            wword_reg <= merged_word;
            state_reg <= ST_WR;
          end else begin
            resp_rdata_reg <= load_data;
            state_reg      <= ST_RESP;
          end
        end
        ST_WR:   state_reg <= ST_RESP;
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_reg == ST_IDLE);
  assign resp_valid     = (state_reg == ST_RESP);
  assign resp_rdata     = resp_rdata_reg;
  assign data_address   = addr_reg;
  assign data_read      = (state_reg == ST_RD);
  assign data_write     = (state_reg == ST_WR);
  assign data_writedata = (state_reg == ST_WR) ? wword_reg : 32'h0;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Self-checking bench for mips_cpu_lsu with a small word memory model on the data port.
module tb_mips_cpu_lsu;
  import mips_cpu_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] mem [0:63];

  int tests_run;
  int tests_failed;

  mips_cpu_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_readdata = mem[data_address[7:2]];

  always @(posedge clk) begin
    if (data_write) mem[data_address[7:2]] <= data_writedata;
  end

  typedef struct {
    lsu_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wword;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one request and watch the cycles after the accept edge (cycle 0).
  task automatic do_req(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nrd, output int nwr, output int nboth,
                        output logic [31:0] wword, output logic ready_after);
    rdata = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; nboth = 0;
    wword = 32'h0; ready_after = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (data_read) nrd++;
      if (data_write) begin
        nwr++;
        wword = data_writedata;
      end
      if (data_read && data_write) nboth++;
      if (resp_valid) begin
        lat   = k;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
    @(negedge clk);
    ready_after = req_ready;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat, nrd, nwr, nboth;
    logic [31:0] wword;
    logic        ready_after;

    tests_run    = 0;
    tests_failed = 0;
    req_valid    = 1'b0;
    req_op       = 3'd0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h8899AABB;

    //        op      addr          wdata         rdata         wword         err   lat nrd nwr
    vecs.push_back('{OP_LB,  32'h1001, 32'h0,        32'hFFFFFF99, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_LBU, 32'h1001, 32'h0,        32'h00000099, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_LH,  32'h1002, 32'h0,        32'hFFFFAABB, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_LHU, 32'h1000, 32'h0,        32'h00008899, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_SB,  32'h1003, 32'h12345677, 32'h0,        32'h8899AA77, 1'b0, 3, 1, 1});
    vecs.push_back('{OP_LW,  32'h1000, 32'h0,        32'h8899AA77, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_SW,  32'h1004, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1});
    vecs.push_back('{OP_LW,  32'h1004, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_SH,  32'h1006, 32'h1234CAFE, 32'h0,        32'hDEADCAFE, 1'b0, 3, 1, 1});
    vecs.push_back('{OP_LB,  32'h1006, 32'h0,        32'hFFFFFFCA, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_LBU, 32'h1000, 32'h0,        32'h00000088, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_LB,  32'h1002, 32'h0,        32'hFFFFFFAA, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_SB,  32'h1004, 32'h00000001, 32'h0,        32'h01ADCAFE, 1'b0, 3, 1, 1});
    vecs.push_back('{OP_LHU, 32'h1004, 32'h0,        32'h000001AD, 32'h0,        1'b0, 2, 1, 0});
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    vecs.push_back('{OP_LW,  32'h1002, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{OP_LB,  32'h0FFC, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{OP_SH,  32'h1001, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{OP_LB,  32'h1100, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{OP_LB,  32'h10FF, 32'h0,        32'h0,        32'h0,        1'b0, 2, 1, 0});
`else
    vecs.push_back('{OP_LW,  32'h1002, 32'h0,        32'h8899AA77, 32'h0,        1'b0, 2, 1, 0});
    vecs.push_back('{OP_LH,  32'h1003, 32'h0,        32'hFFFFAA77, 32'h0,        1'b0, 2, 1, 0});
`endif

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_strobes", {30'h0, data_read, data_write}, 32'h0);
    check("reset_data_address", data_address, 32'h0);
    check("reset_resp", {resp_rdata[30:0], resp_err}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rdata, err, lat, nrd, nwr, nboth, wword, ready_after);
      $display("[TB] vec %0d op=%0d addr=%08h rdata=%08h err=%0b lat=%0d rd=%0d wr=%0d",
               i, vecs[i].op, vecs[i].addr, rdata, err, lat, nrd, nwr);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_reads", i), 32'(nrd), 32'(vecs[i].exp_nrd));
      check($sformatf("v%0d_writes", i), 32'(nwr), 32'(vecs[i].exp_nwr));
      check($sformatf("v%0d_rd_wr_overlap", i), 32'(nboth), 32'h0);
      check($sformatf("v%0d_ready_after", i), 32'(ready_after), 32'h1);
      if (vecs[i].exp_nwr != 0)
        check($sformatf("v%0d_writedata", i), wword, vecs[i].exp_wword);
    end

    // Reset asserted while an SB is in its write cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_SB;
    req_addr  = 32'h1000;
    req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_cycle1_read", 32'(data_read), 32'h1);
    @(negedge clk);
    check("rstwr_cycle2_write", 32'(data_write), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstwr_write_drop", 32'(data_write), 32'h0);
    check("rstwr_ready_in_reset", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset-during-WR: ready=%0b write=%0b mem0=%08h", req_ready, data_write, mem[0]);
    check("rstwr_ready_after", 32'(req_ready), 32'h1);
    check("rstwr_no_write", 32'(data_write), 32'h0);
    check("rstwr_mem_unchanged", mem[0], 32'h8899AA77);

    do_req(OP_LW, 32'h1000, 32'h0, rdata, err, lat, nrd, nwr, nboth, wword, ready_after);
    $display("[TB] post-reset LW addr=00001000 rdata=%08h lat=%0d", rdata, lat);
    check("post_reset_lw_rdata", rdata, 32'h8899AA77);
    check("post_reset_lw_latency", 32'(lat), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
